pixel_fb_writer: RTL and testbench

- Receiving end of the pixel-plot stream that drawing blocks (rocket, invaders, game-over screen) emit as x/y/colour/draw-enable.
- Buffers plot requests in a small FIFO and converts each (x,y) to a linear framebuffer address (y*160+x).
- Writes the 160x120x3 framebuffer through a single memory port, which it shares with the VGA scan-out reader; scan-out reads always win.
- Also provides a hardware full-screen clear, so drawing FSMs no longer walk 19200 pixels themselves.

---
 rtl/pixel_fb_writer_pkg.sv | 28 ++
 rtl/pixel_fb_writer_plot_fifo.sv | 64 ++++++
 rtl/pixel_fb_writer.sv | 185 ++++++++++++++++++
 tb/tb_pixel_fb_writer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fb_writer_pkg.sv
// pixel_fb_writer_pkg
//   Shared framebuffer constants, the writer FSM state encoding and the
//   (x,y) -> linear address helper. The rocket and scan-out blocks import
//   this package as well, so they all agree on geometry and widths.
package pixel_fb_writer_pkg;

  localparam int X_SCREEN_PIXELS = 160;
  localparam int Y_SCREEN_PIXELS = 120;
  localparam int FB_SIZE         = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int COLOUR_W        = 3;
  localparam int FB_ADDR_W       = 15;
  localparam int X_W             = 8;
  localparam int Y_W             = 7;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DRAIN      = 2'd1,
    S_CLEAR      = 2'd2,
    S_CLEAR_DONE = 2'd3
  } fb_state_e;

  // y*160 + x built from shifts: 160 = 128 + 32.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [X_W-1:0] px,
                                                   input logic [Y_W-1:0] py);
    return (FB_ADDR_W'(py) << 7) + (FB_ADDR_W'(py) << 5) + FB_ADDR_W'(px);
  endfunction

endpackage

// File: rtl/pixel_fb_writer_plot_fifo.sv
// plot_fifo
//   Small synchronous FIFO holding pending plot requests ({addr,colour}).
//   Pointer based; DEPTH must be a power of two (>= 2) so the pointers wrap
//   naturally. Read data is combinational from the head entry.
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, wdata_i    write an entry (ignored when full)
//   pop_i, rdata_o     remove the head entry (ignored when empty)
//   full_o, empty_o    occupancy flags
//   count_o            current occupancy, 0..DEPTH
module plot_fifo #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = store_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) store_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer
//   Receives the x/y/colour/plot stream from the drawing blocks, queues the
//   requests and writes them into the 160x120x3 framebuffer through a single
//   memory port shared with the VGA scan-out reader. Also performs a
//   hardware full-screen clear.
//
//   state        | meaning
//   S_IDLE       | nothing pending; start drain or clear
//   S_DRAIN      | popping queued plots into the framebuffer
//   S_CLEAR      | writing clear colour to addresses 0..FB_SIZE-1
//   S_CLEAR_DONE | last clear pixel written; pulse clear_done next
//
//   Port priority each cycle: scan-out read, then clear write, then FIFO
//   pop. A cycle taken by scan_rd simply stalls clear/drain.
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   x, y, colour, plot, plot_ready  plot request stream (valid/ready)
//   clear_req, clear_colour         start a full-screen clear
//   clear_done, busy                status
//   scan_rd, scan_addr              scan-out read request
//   scan_rdata, scan_valid          scan-out read response (1 cycle later)
//   mem_addr, mem_wdata, mem_wren   registered framebuffer port
//   mem_q                           framebuffer read data
//   drop_count                      saturating count of off-screen plots
module pixel_fb_writer
  import pixel_fb_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = FB_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [X_W-1:0]        x,
  input  logic [Y_W-1:0]        y,
  input  logic [COLOUR_W-1:0]   colour,
  input  logic                  plot,
  output logic                  plot_ready,
  input  logic                  clear_req,
  input  logic [COLOUR_W-1:0]   clear_colour,
  output logic                  clear_done,
  output logic                  busy,
  input  logic                  scan_rd,
  input  logic [ADDR_WIDTH-1:0] scan_addr,
  output logic [COLOUR_W-1:0]   scan_rdata,
  output logic                  scan_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [COLOUR_W-1:0]   mem_wdata,
  output logic                  mem_wren,
  input  logic [COLOUR_W-1:0]   mem_q,
  output logic [7:0]            drop_count
);

  localparam int ENTRY_W = ADDR_WIDTH + COLOUR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_W-1:0]        X_LIM     = X_W'(X_SCREEN_PIXELS);
  localparam logic [Y_W-1:0]        Y_LIM     = Y_W'(Y_SCREEN_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_SIZE - 1);

  fb_state_e             state_q;
  logic                  ready_en_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [COLOUR_W-1:0]   clr_colour_q;
  logic                  clear_done_q;
  logic                  scan_valid_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [COLOUR_W-1:0]   mem_wdata_q;
  logic                  mem_wren_q;
  logic [7:0]            drop_q;
  logic [7:0]            drop_d;

  logic                  in_range;
  logic                  accept;
  logic                  push;
  logic                  drop_inc;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_wdata;
  logic [ENTRY_W-1:0]    fifo_rdata;
  logic [ADDR_WIDTH-1:0] fifo_addr;
  logic [COLOUR_W-1:0]   fifo_colour;

  // ready_en_q keeps plot_ready low until the first clock after reset.
  assign plot_ready = ready_en_q && !fifo_full && (state_q != S_CLEAR);
  assign busy       = (state_q == S_CLEAR) || (fifo_count != '0);
  assign clear_done = clear_done_q;
  assign scan_valid = scan_valid_q;
  // Gate with scan_valid so the read bus stays quiet outside responses.
  assign scan_rdata = scan_valid_q ? mem_q : '0;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wren   = mem_wren_q;
  assign drop_count = drop_q;

  always_comb begin
    in_range   = (x < X_LIM) && (y < Y_LIM);
    accept     = plot && plot_ready;
    push       = accept && in_range;
    drop_inc   = accept && !in_range;
    pop        = (state_q == S_DRAIN) && !scan_rd && !fifo_empty;
    fifo_wdata = {ADDR_WIDTH'(fb_addr(x, y)), colour};
    drop_d     = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  assign fifo_addr   = fifo_rdata[ENTRY_W-1:COLOUR_W];
  assign fifo_colour = fifo_rdata[COLOUR_W-1:0];

  plot_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_plot_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ready_en_q   <= 1'b0;
      clr_cnt_q    <= '0;
      clr_colour_q <= '0;
      clear_done_q <= 1'b0;
      scan_valid_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wren_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      ready_en_q   <= 1'b1;
      clear_done_q <= 1'b0;
      scan_valid_q <= scan_rd;
      mem_wren_q   <= 1'b0;
      drop_q       <= drop_d;

      // Memory port arbitration; mem_wdata is left alone on reads.
      if (scan_rd) begin
        mem_addr_q <= scan_addr;
      end else if (state_q == S_CLEAR) begin
        mem_addr_q  <= clr_cnt_q;
        mem_wdata_q <= clr_colour_q;
        mem_wren_q  <= 1'b1;
      end else if (pop) begin
        mem_addr_q  <= fifo_addr;
        mem_wdata_q <= fifo_colour;
        mem_wren_q  <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_q <= S_DRAIN;
          end else if (clear_req) begin
            state_q      <= S_CLEAR;
            clr_colour_q <= clear_colour;
            clr_cnt_q    <= '0;
          end
        end
        S_DRAIN: begin
          // A push this cycle keeps us draining instead of bouncing to idle.
          if (fifo_empty && !push) state_q <= S_IDLE;
        end
        S_CLEAR: begin
          if (!scan_rd) begin
            if (clr_cnt_q == LAST_ADDR) state_q <= S_CLEAR_DONE;
            else clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          end
        end
        S_CLEAR_DONE: begin
          clear_done_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Testbench for pixel_fb_writer: scoreboard of expected framebuffer writes
// and scan-out responses, filled by the stimulus and drained by a monitor.
module tb_pixel_fb_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic [2:0]  colour = '0;
  logic        plot = 1'b0;
  logic        plot_ready;
  logic        clear_req = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic        clear_done;
  logic        busy;
  logic        scan_rd = 1'b0;
  logic [14:0] scan_addr = '0;
  logic [2:0]  scan_rdata;
  logic        scan_valid;
  logic [14:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        mem_wren;
  logic [2:0]  mem_q;
  logic [7:0]  drop_count;

  pixel_fb_writer dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .plot_ready(plot_ready), .clear_req(clear_req), .clear_colour(clear_colour),
    .clear_done(clear_done), .busy(busy), .scan_rd(scan_rd), .scan_addr(scan_addr),
    .scan_rdata(scan_rdata), .scan_valid(scan_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Framebuffer model: combinational read of the registered address.
  logic [2:0] fb [32768];
  bit         fb_init = 1'b0;
  always @(posedge clk) begin
    if (!fb_init) begin
      for (int i = 0; i < 32768; i++) fb[i] <= 3'($urandom);
      fb_init <= 1'b1;
    end else if (mem_wren) begin
      fb[mem_addr] <= mem_wdata;
    end
  end
  assign mem_q = fb[mem_addr];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  typedef struct { logic [14:0] a; logic [2:0] d; } wr_t;
  typedef struct { logic [14:0] a; int unsigned due; } sc_t;
  wr_t exp_wr[$];
  sc_t exp_sc[$];
  int unsigned wr_cnt = 0;
  int unsigned last_wr_cyc = 0;

  // Monitor
  always @(negedge clk) begin
    wr_t e;
    sc_t s;
    if (mem_wren) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_wr.size() == 0) begin
        fail("unexpected_write", $sformatf("got addr=%0d data=%0d, required no write", mem_addr, mem_wdata));
      end else begin
        e = exp_wr.pop_front();
        chk("write_addr_data", {14'd0, mem_addr, mem_wdata}, {14'd0, e.a, e.d});
      end
    end
    if (scan_valid) begin
      if (exp_sc.size() == 0) begin
        fail("unexpected_scan_valid", "got scan_valid=1, required 0");
      end else begin
        s = exp_sc.pop_front();
        chk("scan_latency", cyc, s.due);
        chk("scan_rdata", 32'(scan_rdata), 32'(fb[s.a]));
      end
    end else if (exp_sc.size() > 0 && exp_sc[0].due <= cyc) begin
      s = exp_sc.pop_front();
      fail("scan_valid_missing", $sformatf("got scan_valid=0 in cycle %0d, required 1", cyc));
    end
  end

  int  drop_m = 0;
  int  nacc = 0;
  int unsigned last_acc_cyc = 0;
  int unsigned cur_cyc = 0;
  bit  last_ready = 1'b0;
  int unsigned kc = 0;

  // One clock of stimulus; the acceptance decision is the plot/plot_ready
  // handshake seen just before the capturing edge.
  task automatic cycle_drive(input bit p, input logic [7:0] px, input logic [6:0] py,
                             input logic [2:0] pc, input bit s, input logic [14:0] sa);
    @(posedge clk);
    #1;
    plot = p; x = px; y = py; colour = pc; scan_rd = s; scan_addr = sa;
    cur_cyc = cyc;
    @(negedge clk);
    last_ready = plot_ready;
    if (s) exp_sc.push_back('{a: sa, due: cyc + 1});
    if (p && plot_ready) begin
      nacc++;
      last_acc_cyc = cyc;
      if (int'(px) < 160 && int'(py) < 120)
        exp_wr.push_back('{a: 15'(int'(py) * 160 + int'(px)), d: pc});
      else if (drop_m < 255)
        drop_m++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 15'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) idle(1);
    idle(2);
    if (busy) fail("wait_idle", "busy still 1 after 200 cycles, required 0");
  endtask

  task automatic start_clear(input logic [2:0] col);
    @(posedge clk);
    #1;
    plot = 1'b0; scan_rd = 1'b0; clear_req = 1'b1; clear_colour = col;
    kc = cyc;
    for (int a = 0; a < 19200; a++) exp_wr.push_back('{a: 15'(a), d: col});
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  initial begin
    int unsigned w0;
    int unsigned dcyc;
    int          n0;
    int          n_ready;
    int          n_scan;
    bit          done;
    bit          hit;
    int unsigned scan_cycles[$];

    // Reset state
    #12;
    chk("rst_plot_ready", 32'(plot_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clear_done", 32'(clear_done), 0);
    chk("rst_scan_valid", 32'(scan_valid), 0);
    chk("rst_mem_wren", 32'(mem_wren), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ready_before_first_clock", 32'(plot_ready), 0);
    @(posedge clk);
    #1;
    chk("ready_after_first_clock", 32'(plot_ready), 1);

    // 1: single plot latency and address
    cycle_drive(1'b1, 8'd5, 7'd2, 3'b101, 1'b0, 15'd0);
    chk("t1_accepted", 32'(nacc), 1);
    w0 = wr_cnt;
    for (int i = 0; i < 10 && wr_cnt == w0; i++) idle(1);
    if (wr_cnt == w0) fail("t1_write_timeout", "no write within 10 cycles");
    else chk("t1_latency", last_wr_cyc - last_acc_cyc, 3);
    chk("t1_drop_count", 32'(drop_count), 0);

    // Corners: (0,0) -> 0 and (159,119) -> 19199
    cycle_drive(1'b1, 8'd0, 7'd0, 3'd1, 1'b0, 15'd0);
    cycle_drive(1'b1, 8'd159, 7'd119, 3'd6, 1'b0, 15'd0);
    wait_idle();

    // Randomised plots with interleaved scan reads
    for (int i = 0; i < 400; i++) begin
      cycle_drive(($urandom % 3) != 0, 8'($urandom_range(0, 175)), 7'($urandom_range(0, 127)),
                  3'($urandom), ($urandom % 6) == 0, 15'($urandom_range(0, 19199)));
    end
    wait_idle();
    chk("rand_drop_count", 32'(drop_count), 32'(drop_m));
    chk("rand_all_written", exp_wr.size(), 0);

    // 2: off-screen plots, then saturation
    w0 = wr_cnt;
    drop_m = 0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    idle(1);
    cycle_drive(1'b1, 8'd160, 7'd10, 3'd1, 1'b0, 15'd0);
    cycle_drive(1'b1, 8'd10, 7'd120, 3'd1, 1'b0, 15'd0);
    idle(4);
    chk("t2_drop_two", 32'(drop_count), 2);
    chk("t2_no_write", wr_cnt - w0, 0);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) cycle_drive(1'b1, 8'($urandom_range(160, 255)), 7'($urandom), 3'd0, 1'b0, 15'd0);
      else cycle_drive(1'b1, 8'($urandom), 7'($urandom_range(120, 127)), 3'd0, 1'b0, 15'd0);
    end
    idle(2);
    chk("t2_drop_saturated", 32'(drop_count), 255);
    chk("t2_drop_model", 32'(drop_count), 32'(drop_m));

    // 3: scan reads hold off draining of a full FIFO
    wait_idle();
    n0 = nacc;
    w0 = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      cycle_drive(i < 4, 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'($urandom),
                  1'b1, 15'($urandom_range(0, 19199)));
      if (i == 4) chk("t3_full_ready", 32'(plot_ready), 0);
    end
    chk("t3_accepted", nacc - n0, 4);
    idle(1);
    chk("t3_no_write_during_scan", wr_cnt - w0, 0);
    idle(4);
    chk("t3_drain_burst", wr_cnt - w0, 4);
    wait_idle();

    // 4: uncontended clear with plots presented throughout
    start_clear(3'b010);
    n_ready = 0;
    done = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 25000 && !done; i++) begin
      cycle_drive(1'b1, 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'($urandom),
                  1'b0, 15'd0);
      if (i == 2) clear_req = 1'b0;
      if (last_ready) n_ready++;
      if (clear_done) begin
        done = 1'b1;
        dcyc = cyc;
      end
    end
    if (!done) begin
      fail("t4_clear_done_timeout", "no clear_done within 25000 cycles");
    end else begin
      chk("t4_clear_len", dcyc - kc, 19202);
      // Ready only in the done-state cycle and the pulse cycle that follows.
      chk("t4_ready_held_off", 32'(n_ready), 2);
    end
    idle(1);
    chk("t4_done_one_cycle", 32'(clear_done), 0);
    plot = 1'b0;
    wait_idle();
    chk("t4_all_written", exp_wr.size(), 0);

    // 5: clear with a scan read every 4th cycle
    start_clear(3'($urandom));
    done = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 30000 && !done; i++) begin
      cycle_drive(1'b0, 8'd0, 7'd0, 3'd0, (i % 4) == 3, 15'($urandom_range(0, 19199)));
      if (i == 2) clear_req = 1'b0;
      if ((i % 4) == 3) scan_cycles.push_back(cur_cyc);
      if (clear_done) begin
        done = 1'b1;
        dcyc = cyc;
      end
    end
    if (!done) begin
      fail("t5_clear_done_timeout", "no clear_done within 30000 cycles");
    end else begin
      n_scan = 0;
      foreach (scan_cycles[i])
        if (scan_cycles[i] >= kc + 1 && scan_cycles[i] <= dcyc - 2) n_scan++;
      chk("t5_clear_len", dcyc - kc - 2, 32'(19200 + n_scan));
    end
    wait_idle();
    chk("t5_all_written", exp_wr.size(), 0);

    // 6: reset in the middle of a clear
    start_clear(3'b111);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      idle(1);
      if (i == 2) clear_req = 1'b0;
      if (mem_wren && mem_addr == 15'd500) hit = 1'b1;
    end
    if (!hit) fail("t6_addr500_timeout", "clear never reached address 500");
    reset = 1'b0;
    #1;
    chk("t6_mem_wren", 32'(mem_wren), 0);
    chk("t6_mem_addr", 32'(mem_addr), 0);
    chk("t6_mem_wdata", 32'(mem_wdata), 0);
    chk("t6_plot_ready", 32'(plot_ready), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_clear_done", 32'(clear_done), 0);
    chk("t6_drop_count", 32'(drop_count), 0);
    exp_wr.delete();
    drop_m = 0;
    clear_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_ready_after_release", 32'(plot_ready), 1);
    chk("t6_busy_after_release", 32'(busy), 0);
    w0 = wr_cnt;
    idle(20);
    chk("t6_no_writes", wr_cnt - w0, 0);

    chk("final_write_queue_empty", exp_wr.size(), 0);
    chk("final_scan_queue_empty", exp_sc.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
